// File: rtl/rv32i_types.sv
// Shared RV32I types for the front end: base opcode enum and the fetch packet
// carried from fetch to decode.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fetch_pkt_t;

endpackage

// File: rtl/if_predecode.sv
// Combinational JAL predecode: flags a direct jump and computes its target so
// fetch can redirect before the instruction reaches decode.
import rv32i_types::*;

module if_predecode (
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    output logic        direct_jump_raw,
    output logic [31:0] jump_target
);

    logic [31:0] j_imm;

    assign j_imm = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};

    assign direct_jump_raw = (instruction[6:0] == op_jal);
    assign jump_target     = pc + j_imm;

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry circular FIFO of fetch packets with head
// JAL predecode and single-cycle flush. Optional bypass: IF_ID_QUEUE_BYPASS_EN.
import rv32i_types::*;

module if_id_queue #(
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [31:0]                  instruction_in,
    input  logic [31:0]                  pc_in,
    input  logic [31:0]                  pc_plus4_in,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [31:0]                  instruction_out,
    output logic [31:0]                  pc_out,
    output logic [31:0]                  pc_plus4_out,
    output logic                         direct_jump,
    output logic [31:0]                  jump_target,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

    fetch_pkt_t    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    fetch_pkt_t in_pkt;
    fetch_pkt_t head_pkt;
    logic       full;
    logic       empty;
    logic       bypass;
    logic       head_valid;
    logic       store_enq;
    logic       store_deq;
    logic       direct_jump_raw;

    assign in_pkt = '{instruction: instruction_in, pc: pc_in, pc_plus4: pc_plus4_in};

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign enq_ready = !full;

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass = empty && enq_valid && !flush && !rst;
`else
    assign bypass = 1'b0;
`endif

    assign head_valid = !empty || bypass;
    assign head_pkt   = bypass ? in_pkt : mem[rd_ptr];

    // A bypassed packet taken by decode in the same cycle is never stored.
    assign store_enq = enq_valid && enq_ready && !flush && !(bypass && deq_ready);
    assign store_deq = head_valid && deq_ready && !bypass && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (store_enq) wr_ptr <= wr_ptr + PW'(1);
            if (store_deq) rd_ptr <= rd_ptr + PW'(1);
            case ({store_enq, store_deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store_enq && !rst) mem[wr_ptr] <= in_pkt;
    end

    if_predecode u_predecode (
        .instruction     (head_pkt.instruction),
        .pc              (head_pkt.pc),
        .direct_jump_raw (direct_jump_raw),
        .jump_target     (jump_target)
    );

    always_comb begin
        deq_valid       = head_valid;
        instruction_out = '0;
        pc_out          = '0;
        pc_plus4_out    = '0;
        direct_jump     = 1'b0;
        if (head_valid) begin
            instruction_out = head_pkt.instruction;
            pc_out          = head_pkt.pc;
            pc_plus4_out    = head_pkt.pc_plus4;
            direct_jump     = direct_jump_raw;
        end
    end

    assign almost_full = (count >= AFULL_C);

endmodule
